// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO read path.
// Word width defaults, word type and the prefetch credit helper.
package fifo_pkg;

   localparam int DATA_SIZE = 8;
   localparam int ADDR_SIZE = 4;
   localparam int BUF_DEPTH = 2;

   typedef logic [DATA_SIZE-1:0] fifo_word_t;

   // True when buffered + in-flight words after this cycle's
   // dequeue leave room for one more popped word.
   function automatic logic has_credit(
      input logic [1:0] count,
      input logic       inflight,
      input logic       deq
   );
      logic [2:0] used;
      used = {1'b0, count}
           + {2'b00, inflight}
           - {2'b00, deq};
      return used < 3'(BUF_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Two-entry head/tail holding buffer for the FIFO read stream.
// Head is the presented word; tail backs it up under stalls.
module rd_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = fifo_pkg::DATA_SIZE
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 load,
   input  logic [DATA_SIZE-1:0] din,
   input  logic                 deq,
   output logic [1:0]           count,
   output logic [DATA_SIZE-1:0] head
);

   logic [DATA_SIZE-1:0] head_q, head_d;
   logic [DATA_SIZE-1:0] tail_q, tail_d;
   logic [1:0]           count_q, count_d;

   // Next-state: write into first free slot after the dequeue.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      unique case ({load, deq})
         2'b11: begin
            if (count_q == 2'd2) begin
               head_d = tail_q;
               tail_d = din;
            end else begin
               head_d = din;
            end
         end
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d  = din;
               count_d = 2'd1;
            end else if (count_q == 2'd1) begin
               tail_d  = din;
               count_d = 2'd2;
            end
         end
         2'b01: begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
         end
         default: begin
         end
      endcase
   end

   // Buffer registers; reset drops any held words.
   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = head_q;

   // The credit gate upstream must never let a word land on a full buffer.
   ovf_chk: assert property (
      @(posedge rclk) disable iff (!rrst)
      !(load && !deq && count_q == 2'd2)
   );

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side stream stage of the async FIFO: pops the memory
// on credit and presents words as a registered valid/ready stream.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = fifo_pkg::DATA_SIZE
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 rEmpty,
   output logic                 rinc,
   input  logic [DATA_SIZE-1:0] rdata,
   input  logic                 en,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data,
   input  logic                 out_ready,
   output logic [1:0]           level
);

   logic                 inflight;
   logic                 deq;
   logic [1:0]           count;
   logic [DATA_SIZE-1:0] head;

   assign out_valid = (count != 2'd0);
   assign deq       = out_valid & out_ready;

   // rEmpty is used directly so the last word never over-pops;
   // rrst gates the pop so nothing escapes during reset.
   assign rinc = rrst & en & ~rEmpty
               & has_credit(count, inflight, deq);

   // rdata is valid exactly one cycle after a pop edge.
   always_ff @(posedge rclk or negedge rrst) begin
      if (!rrst) inflight <= 1'b0;
      else       inflight <= rinc;
   end

   rd_skid_buf #(
      .DATA_SIZE(DATA_SIZE)
   ) u_buf (
      .rclk  (rclk),
      .rrst  (rrst),
      .load  (inflight),
      .din   (rdata),
      .deq   (deq),
      .count (count),
      .head  (head)
   );

   assign out_data = head;
   assign level    = count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO/memory model drives the pop side,
// a queue model and end-to-end scoreboard check the stream side.
module tb_fifo_rd_stream;

   localparam int W = 8;

   logic         rclk = 1'b0;
   logic         rrst;
   logic         rEmpty;
   logic         rinc;
   logic [W-1:0] rdata;
   logic         en;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic [1:0]   level;

   fifo_rd_stream #(.DATA_SIZE(W)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rEmpty    (rEmpty),
      .rinc      (rinc),
      .rdata     (rdata),
      .en        (en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .level     (level)
   );

   always #5 rclk = ~rclk;

   int total = 0;
   int bad = 0;
   int delivered = 0;
   int pulses = 0;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] sb[$];
   logic [W-1:0] mbuf[$];
   bit           m_inflight;
   logic [W-1:0] m_word;

   bit           s_rempty;
   bit           s_valid;
   bit           s_deq;
   logic [W-1:0] s_data;

   task automatic write_word(input logic [W-1:0] w);
      fifo_q.push_back(w);
      sb.push_back(w);
   endtask

   task automatic clear_models();
      fifo_q.delete();
      sb.delete();
      mbuf.delete();
      m_inflight = 1'b0;
      rEmpty = 1'b1;
   endtask

   // One clock: check at negedge+1, then advance FIFO and model.
   task automatic cycle();
      bit           exp_deq;
      bit           exp_rinc;
      bit           pop;
      int           used;
      logic [W-1:0] want;
      #1;
      exp_deq = (mbuf.size() != 0) && out_ready;
      used = mbuf.size() + int'(m_inflight) - int'(exp_deq);
      exp_rinc = en && !rEmpty && (used < 2);
      total++;
      if (out_valid !== (mbuf.size() != 0)) begin
         bad++;
         $display("FAIL out_valid got=%b want=%b",
                  out_valid, mbuf.size() != 0);
      end
      total++;
      if (level !== 2'(mbuf.size())) begin
         bad++;
         $display("FAIL level got=%0d want=%0d",
                  level, mbuf.size());
      end
      total++;
      if (rinc !== exp_rinc) begin
         bad++;
         $display("FAIL rinc got=%b want=%b", rinc, exp_rinc);
      end
      if (mbuf.size() != 0) begin
         total++;
         if (out_data !== mbuf[0]) begin
            bad++;
            $display("FAIL head got=%h want=%h",
                     out_data, mbuf[0]);
         end
      end
      s_rempty = rEmpty;
      s_valid = out_valid;
      s_data = out_data;
      s_deq = out_valid && out_ready;
      if (s_deq) begin
         total++;
         delivered++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL order got=%h want=none", out_data);
         end else begin
            want = sb.pop_front();
            if (out_data !== want) begin
               bad++;
               $display("FAIL order got=%h want=%h",
                        out_data, want);
            end
         end
      end
      pop = rinc;
      if (pop) pulses++;
      @(posedge rclk);
      if (exp_deq) void'(mbuf.pop_front());
      if (m_inflight) mbuf.push_back(m_word);
      m_inflight = exp_rinc;
      #1;
      if (pop && fifo_q.size() != 0) rdata = fifo_q.pop_front();
      else rdata = W'($urandom);
      m_word = rdata;
      rEmpty = (fifo_q.size() == 0);
      @(negedge rclk);
   endtask

   task automatic test_reset();
      rrst = 1'b0;
      en = 1'b1;
      out_ready = 1'b1;
      rdata = '0;
      clear_models();
      @(negedge rclk);
      total++;
      if (out_valid !== 1'b0 || level !== 2'd0 ||
          rinc !== 1'b0 || out_data !== 8'h00) begin
         bad++;
         $display("FAIL reset got=%b/%0d/%b/%h want=0/0/0/00",
                  out_valid, level, rinc, out_data);
      end
      rrst = 1'b1;
      for (int i = 0; i < 3; i++) cycle();
   endtask

   task automatic test_basic();
      int           nf = -1;
      int           nv = -1;
      int           fd = -1;
      int           ld = -1;
      logic [W-1:0] seq[$];
      logic [W-1:0] ref_seq[3];
      ref_seq[0] = 8'h11;
      ref_seq[1] = 8'h22;
      ref_seq[2] = 8'h33;
      en = 1'b1;
      out_ready = 1'b1;
      write_word(8'h11);
      write_word(8'h22);
      write_word(8'h33);
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (nf < 0 && !s_rempty) nf = i;
         if (nv < 0 && s_valid) nv = i;
         if (s_deq) begin
            seq.push_back(s_data);
            if (fd < 0) fd = i;
            ld = i;
         end
      end
      total++;
      if (nf < 0 || nv - nf != 2) begin
         bad++;
         $display("FAIL latency got=%0d want=2", nv - nf);
      end
      total++;
      if (ld - fd != 2) begin
         bad++;
         $display("FAIL basic_rate got=%0d want=2", ld - fd);
      end
      total++;
      if (seq.size() != 3) begin
         bad++;
         $display("FAIL basic_cnt got=%0d want=3", seq.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (seq[i] !== ref_seq[i]) begin
               bad++;
               $display("FAIL basic_seq got=%h want=%h",
                        seq[i], ref_seq[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] first;
      int           nd = 0;
      int           fd = -1;
      int           ld = -1;
      en = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) write_word(W'($urandom));
      first = fifo_q[0];
      for (int i = 0; i < 6; i++) cycle();
      #1;
      total++;
      if (level !== 2'd2 || rinc !== 1'b0 ||
          out_data !== first) begin
         bad++;
         $display("FAIL stall got=%0d/%b/%h want=2/0/%h",
                  level, rinc, out_data, first);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (s_deq) begin
            nd++;
            if (fd < 0) fd = i;
            ld = i;
         end
      end
      total++;
      if (nd != 10 || ld - fd != 9) begin
         bad++;
         $display("FAIL burst got=%0d/%0d want=10/9",
                  nd, ld - fd);
      end
   endtask

   task automatic test_toggle();
      int d0;
      d0 = delivered;
      en = 1'b1;
      for (int i = 0; i < 8; i++) write_word(W'($urandom));
      for (int i = 0; i < 40; i++) begin
         out_ready = i[0];
         cycle();
      end
      total++;
      if (delivered - d0 != 8 || sb.size() != 0) begin
         bad++;
         $display("FAIL toggle got=%0d want=8", delivered - d0);
      end
   endtask

   task automatic test_en();
      int d0;
      en = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) write_word(W'($urandom));
      for (int i = 0; i < 5; i++) cycle();
      #1;
      total++;
      if (out_valid !== 1'b0 || rinc !== 1'b0) begin
         bad++;
         $display("FAIL en_off got=%b/%b want=0/0",
                  out_valid, rinc);
      end
      en = 1'b1;
      cycle();
      en = 1'b0;
      d0 = delivered;
      for (int i = 0; i < 6; i++) cycle();
      total++;
      if (delivered - d0 != 1) begin
         bad++;
         $display("FAIL en_drop got=%0d want=1", delivered - d0);
      end
      en = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) write_word(W'($urandom));
      for (int i = 0; i < 5; i++) cycle();
      #2;
      rrst = 1'b0;
      clear_models();
      #1;
      total++;
      if (out_valid !== 1'b0 || level !== 2'd0 ||
          rinc !== 1'b0 || out_data !== 8'h00) begin
         bad++;
         $display("FAIL async_rst got=%b/%0d/%b/%h want=0/0/0/00",
                  out_valid, level, rinc, out_data);
      end
      @(negedge rclk);
      rrst = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      total++;
      if (s_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_rst got=%b want=0", s_valid);
      end
   endtask

   task automatic test_single();
      en = 1'b1;
      out_ready = 1'b0;
      pulses = 0;
      write_word(8'hA5);
      for (int i = 0; i < 6; i++) cycle();
      total++;
      if (s_valid !== 1'b1) begin
         bad++;
         $display("FAIL single_hold got=%b want=1", s_valid);
      end
      out_ready = 1'b1;
      cycle();
      cycle();
      total++;
      if (s_valid !== 1'b0 || pulses != 1) begin
         bad++;
         $display("FAIL single got=%b/%0d want=0/1",
                  s_valid, pulses);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 2) == 0) write_word(W'($urandom));
         cycle();
      end
      en = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (sb.size() != 0) cycle();
      end
      for (int i = 0; i < 3; i++) cycle();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d want=0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_toggle();
      test_en();
      test_reset_mid();
      test_single();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
